// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 stream engine: register map,
// CTRL/STATUS bit positions, engine FSM encoding and the PRESENT
// round primitives (S-box, bit permutation, key schedule steps).
package present_pkg;

    localparam logic [3:0] ADDR_CTRL    = 4'd0;
    localparam logic [3:0] ADDR_KEY1    = 4'd1;
    localparam logic [3:0] ADDR_KEY2    = 4'd2;
    localparam logic [3:0] ADDR_KEY3    = 4'd3;
    localparam logic [3:0] ADDR_DIN_HI  = 4'd4;
    localparam logic [3:0] ADDR_DIN_LO  = 4'd5;
    localparam logic [3:0] ADDR_DOUT_HI = 4'd6;
    localparam logic [3:0] ADDR_DOUT_LO = 4'd7;
    localparam logic [3:0] ADDR_STATUS  = 4'd8;
    localparam logic [3:0] ADDR_IV_HI   = 4'd9;
    localparam logic [3:0] ADDR_IV_LO   = 4'd10;

    localparam int CTRL_DIR    = 0;
    localparam int CTRL_CBC    = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_FLUSH  = 3;

    localparam int ST_ERR_TIMEOUT = 5;
    localparam int ST_ERR_OVF     = 6;
    localparam int ST_ERR_UNF     = 7;
    localparam int ST_ERR_CFG     = 8;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE} eng_state_e;

    // Nibble n of each LUT holds S(n) / S^-1(n).
    localparam logic [63:0] SBOX_LUT     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV_LUT = 64'hA970364BD21C8FE5;

    function automatic logic [3:0] s4(input logic [3:0] x, input logic inv);
        return inv ? SBOX_INV_LUT[{x, 2'b00} +: 4] : SBOX_LUT[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s, input logic inv);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = s4(s[4*n +: 4], inv);
        return r;
    endfunction

    // Bit i moves to 16*i mod 63 (bit 63 stays put).
    function automatic logic [63:0] p_layer(input logic [63:0] s, input logic inv);
        logic [63:0] r;
        int p;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            p = (i == 63) ? 63 : (i * 16) % 63;
            if (inv) r[i] = s[p];
            else     r[p] = s[i];
        end
        return r;
    endfunction

    function automatic logic [79:0] key_next(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = s4(r[79:76], 1'b0);
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

    function automatic logic [79:0] key_prev(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = k;
        r[19:15] = r[19:15] ^ rc;
        r[79:76] = s4(r[79:76], 1'b1);
        return {r[60:0], r[79:61]};
    endfunction

endpackage

// File: rtl/present_block_fifo.sv
// Block FIFO for 64-bit cipher blocks.
// Ports: push_i/din_i enqueue, pop_i dequeues the head shown on dout_o,
// flush_i empties the queue; full_o/empty_o/count_o report occupancy.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module present_block_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_FULL);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy tracking; flush overrides push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/present_core.sv
// Iterative PRESENT-80 block cipher, one round per cycle.
// Ports: iLoad starts a block (idat, ikey, iControl 0=enc/1=dec);
// oDone pulses for one cycle when odat holds the result.
// Decryption first runs the key schedule forward to K32, then walks it back.
module PRESENT_CORE
    import present_pkg::*;
(
    input  logic        clk,
    input  logic        iReset_n,
    input  logic        iLoad,
    input  logic        iControl,
    input  logic [63:0] idat,
    input  logic [79:0] ikey,
    output logic [63:0] odat,
    output logic        oDone
);
    typedef enum logic [1:0] {C_IDLE, C_ENC, C_KEYGEN, C_DEC} core_state_e;

    core_state_e st_q;
    logic [63:0] state_q;
    logic [79:0] key_q;
    logic [5:0]  rnd_q;
    logic        done_q;

    assign odat  = state_q;
    assign oDone = done_q;

    // Round sequencer; a new load always restarts the core.
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            st_q    <= C_IDLE;
            state_q <= 64'd0;
            key_q   <= 80'd0;
            rnd_q   <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (iLoad) begin
                state_q <= idat;
                key_q   <= ikey;
                rnd_q   <= 6'd1;
                st_q    <= iControl ? C_KEYGEN : C_ENC;
            end else begin
                case (st_q)
                    C_ENC: begin
                        if (rnd_q == 6'd32) begin
                            state_q <= state_q ^ key_q[79:16];
                            done_q  <= 1'b1;
                            st_q    <= C_IDLE;
                        end else begin
                            state_q <= p_layer(sbox_layer(state_q ^ key_q[79:16], 1'b0), 1'b0);
                            key_q   <= key_next(key_q, rnd_q[4:0]);
                            rnd_q   <= rnd_q + 6'd1;
                        end
                    end
                    C_KEYGEN: begin
                        if (rnd_q == 6'd32) begin
                            state_q <= state_q ^ key_q[79:16];
                            key_q   <= key_prev(key_q, 5'd31);
                            rnd_q   <= 6'd31;
                            st_q    <= C_DEC;
                        end else begin
                            key_q <= key_next(key_q, rnd_q[4:0]);
                            rnd_q <= rnd_q + 6'd1;
                        end
                    end
                    C_DEC: begin
                        state_q <= sbox_layer(p_layer(state_q, 1'b1), 1'b1) ^ key_q[79:16];
                        key_q   <= key_prev(key_q, rnd_q[4:0] - 5'd1);
                        rnd_q   <= rnd_q - 6'd1;
                        if (rnd_q == 6'd1) begin
                            done_q <= 1'b1;
                            st_q   <= C_IDLE;
                        end
                    end
                    default: st_q <= C_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/present_stream_engine.sv
// Bus-mapped PRESENT-80 stream engine (ECB/CBC) with input/output block FIFOs.
// Ports: clk, iReset (async, active high), iChipselect_n/iWrite_n/iRead_n
// strobes, iAddress word address, idat write data, odat registered read
// data, oIrq level interrupt.
module present_stream_engine
    import present_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        iReset,
    input  logic        iChipselect_n,
    input  logic        iWrite_n,
    input  logic        iRead_n,
    input  logic [3:0]  iAddress,
    input  logic [31:0] idat,
    output logic [31:0] odat,
    output logic        oIrq
);
    localparam int ICW = $clog2(IN_DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = TIMEOUT[WDW-1:0];
    localparam logic [WDW-1:0] WD_ONE   = 1;

    eng_state_e     state_q;
    logic           dir_q, cbc_q, irq_en_q;
    logic [79:0]    key_q;
    logic [63:0]    iv_q, iv_d, chain_q, blk_q, core_din_q, res_q;
    logic [31:0]    din_hi_q, rd_data;
    logic           core_load_q, out_push_q;
    logic [WDW-1:0] wdog_q;
    logic           err_timeout_q, err_ovf_q, err_unf_q, err_cfg_q;
    logic [31:0]    odat_q;
    logic           irq_q;

    logic           wr_en, rd_en, busy, flush, ctrl_wr, key_wr, iv_wr, cfg_change;
    logic           in_push, in_pop, out_push, out_pop, timeout_hit;
    logic           in_full, in_empty, out_full, out_empty, core_done;
    logic [63:0]    in_head, out_head, core_out;
    logic [ICW-1:0] in_cnt;
    logic [OCW-1:0] out_cnt;
    logic [3:0]     w1c;

    assign wr_en   = ~iChipselect_n & ~iWrite_n;
    assign rd_en   = ~iChipselect_n & ~iRead_n & iWrite_n;
    assign busy    = (state_q != S_IDLE);
    assign ctrl_wr = wr_en && (iAddress == ADDR_CTRL);
    assign flush   = ctrl_wr & idat[CTRL_FLUSH];
    assign key_wr  = wr_en && (iAddress == ADDR_KEY1 || iAddress == ADDR_KEY2 || iAddress == ADDR_KEY3);
    assign iv_wr   = wr_en && (iAddress == ADDR_IV_HI || iAddress == ADDR_IV_LO);
    // Only a CTRL write that would actually change dir/cbc counts as a config clash.
    assign cfg_change = ctrl_wr && (idat[1:0] != {cbc_q, dir_q});

    assign in_push     = wr_en && (iAddress == ADDR_DIN_LO);
    assign in_pop      = (state_q == S_IDLE) & ~in_empty & ~out_full & ~flush;
    assign out_push    = out_push_q & ~flush;
    assign out_pop     = rd_en && (iAddress == ADDR_DOUT_LO) && !out_empty;
    assign timeout_hit = (state_q == S_WAIT) && !core_done && (wdog_q >= WD_LIMIT) && !flush;
    assign w1c         = (wr_en && iAddress == ADDR_STATUS) ? idat[8:5] : 4'd0;

    present_block_fifo #(.WIDTH(64), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(clk), .rst(iReset), .push_i(in_push), .pop_i(in_pop), .flush_i(flush),
        .din_i({din_hi_q, idat}), .dout_o(in_head), .full_o(in_full),
        .empty_o(in_empty), .count_o(in_cnt)
    );

    present_block_fifo #(.WIDTH(64), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clk), .rst(iReset), .push_i(out_push), .pop_i(out_pop), .flush_i(flush),
        .din_i(res_q), .dout_o(out_head), .full_o(out_full),
        .empty_o(out_empty), .count_o(out_cnt)
    );

    PRESENT_CORE u_core (
        .clk(clk), .iReset_n(~iReset), .iLoad(core_load_q), .iControl(dir_q),
        .idat(core_din_q), .ikey(key_q), .odat(core_out), .oDone(core_done)
    );

    // IV after the current bus write (ignored while busy).
    always_comb begin
        iv_d = iv_q;
        if (iv_wr && !busy) begin
            if (iAddress == ADDR_IV_HI) iv_d[63:32] = idat;
            else                        iv_d[31:0]  = idat;
        end else begin
            iv_d = iv_q;
        end
    end

    // Engine FSM: fetch a block, run the core, push the (chained) result.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            blk_q       <= 64'd0;
            core_din_q  <= 64'd0;
            core_load_q <= 1'b0;
            res_q       <= 64'd0;
            out_push_q  <= 1'b0;
            wdog_q      <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            core_load_q <= 1'b0;
            out_push_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_pop) begin
                    blk_q       <= in_head;
                    core_din_q  <= (cbc_q & ~dir_q) ? (in_head ^ chain_q) : in_head;
                    core_load_q <= 1'b1;
                    wdog_q      <= '0;
                    state_q     <= S_LOAD;
                end
                S_LOAD: begin
                    core_load_q <= 1'b0;
                    wdog_q      <= wdog_q + WD_ONE;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        res_q      <= (cbc_q & dir_q) ? (core_out ^ chain_q) : core_out;
                        out_push_q <= 1'b1;
                        state_q    <= S_STORE;
                    end else if (timeout_hit) begin
                        state_q <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_ONE;
                    end
                end
                S_STORE: begin
                    out_push_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Configuration registers, DIN staging and the CBC chaining value.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            dir_q    <= 1'b0;
            cbc_q    <= 1'b0;
            irq_en_q <= 1'b0;
            key_q    <= 80'd0;
            iv_q     <= 64'd0;
            chain_q  <= 64'd0;
            din_hi_q <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= idat[CTRL_IRQ_EN];
                if (!busy) {cbc_q, dir_q} <= idat[1:0];
            end
            if (key_wr && !busy) begin
                case (iAddress)
                    ADDR_KEY1: key_q[79:48] <= idat;
                    ADDR_KEY2: key_q[47:16] <= idat;
                    default:   key_q[15:0]  <= idat[15:0];
                endcase
            end
            if (wr_en && iAddress == ADDR_DIN_HI) din_hi_q <= idat;
            iv_q <= iv_d;
            // For encryption res_q equals the raw core output, so it doubles as the chain value.
            if (flush)                                chain_q <= iv_q;
            else if (iv_wr && !busy)                  chain_q <= iv_d;
            else if (state_q == S_STORE && cbc_q)     chain_q <= dir_q ? blk_q : res_q;
        end
    end

    // Sticky error flags: set wins over a simultaneous W1C.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_unf_q     <= 1'b0;
            err_cfg_q     <= 1'b0;
        end else begin
            err_timeout_q <= (err_timeout_q & ~w1c[0]) | timeout_hit;
            err_ovf_q     <= (err_ovf_q & ~w1c[1]) | (in_push & in_full & ~in_pop);
            err_unf_q     <= (err_unf_q & ~w1c[2]) | (rd_en && iAddress == ADDR_DOUT_LO && out_empty);
            err_cfg_q     <= (err_cfg_q & ~w1c[3]) | (busy & (cfg_change | key_wr | iv_wr));
        end
    end

    // Read data mux.
    always_comb begin
        rd_data = 32'd0;
        case (iAddress)
            ADDR_CTRL:    rd_data = {29'd0, irq_en_q, cbc_q, dir_q};
            ADDR_DOUT_HI: rd_data = out_empty ? 32'd0 : out_head[63:32];
            ADDR_DOUT_LO: rd_data = out_empty ? 32'd0 : out_head[31:0];
            ADDR_STATUS:  rd_data = {8'(out_cnt), 8'(in_cnt), 7'd0, err_cfg_q, err_unf_q,
                                     err_ovf_q, err_timeout_q, out_empty, out_full,
                                     in_empty, in_full, busy};
            default:      rd_data = 32'd0;
        endcase
    end

    // Registered bus read data and interrupt.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            odat_q <= 32'd0;
            irq_q  <= 1'b0;
        end else begin
            if (rd_en) odat_q <= rd_data;
            irq_q <= irq_en_q & (~out_empty | err_timeout_q | err_ovf_q | err_unf_q);
        end
    end

    assign odat = odat_q;
    assign oIrq = irq_q;

endmodule

// File: tb/tb_present_stream_engine.sv
module tb_present_stream_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, wr_n, rd_n;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] odat;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    present_stream_engine dut (
        .clk(clk), .iReset(rst), .iChipselect_n(cs_n), .iWrite_n(wr_n),
        .iRead_n(rd_n), .iAddress(addr), .idat(wdata), .odat(odat), .oIrq(irq)
    );

    typedef struct {
        logic [79:0] key;
        logic        dir;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    localparam logic [63:0] C_K0_P0 = 64'h5579C1387B228445;
    localparam logic [63:0] C_K0_PF = 64'hA112FFC72F68417B;
    localparam logic [63:0] C_KF_P0 = 64'hE72C46C0F5945049;
    localparam logic [63:0] C_KF_PF = 64'h3333DCD3213210D2;
    localparam logic [63:0] ONES64  = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [79:0] ONES80  = 80'hFFFFFFFFFFFFFFFFFFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; addr = a;
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        d = odat;
    endtask

    task automatic set_key(input logic [79:0] k);
        bus_wr(4'd1, k[79:48]);
        bus_wr(4'd2, k[47:16]);
        bus_wr(4'd3, {16'd0, k[15:0]});
    endtask

    task automatic push_blk(input logic [63:0] b);
        bus_wr(4'd4, b[63:32]);
        bus_wr(4'd5, b[31:0]);
    endtask

    task automatic pop_blk(output logic [63:0] b);
        logic [31:0] hi, lo;
        bus_rd(4'd6, hi);
        bus_rd(4'd7, lo);
        b = {hi, lo};
    endtask

    // Poll STATUS until (STATUS & mask) == val, bounded.
    task automatic wait_st(input logic [31:0] mask, input logic [31:0] val, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus_rd(4'd8, s);
            if ((s & mask) == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [31:0] rdv;
        logic [63:0] blk;
        bit          ok;

        vecs[0] = '{80'd0,  1'b0, 64'd0,   C_K0_P0};
        vecs[1] = '{80'd0,  1'b0, ONES64,  C_K0_PF};
        vecs[2] = '{ONES80, 1'b0, 64'd0,   C_KF_P0};
        vecs[3] = '{ONES80, 1'b0, ONES64,  C_KF_PF};
        vecs[4] = '{ONES80, 1'b1, C_KF_PF, ONES64};
        vecs[5] = '{80'd0,  1'b1, C_K0_P0, 64'd0};
        vecs[6] = '{80'd0,  1'b1, C_K0_PF, ONES64};
        vecs[7] = '{ONES80, 1'b1, C_KF_P0, 64'd0};

        rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; addr = 4'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and quiet boundary reads
        chk("reset_odat", {32'd0, odat}, 64'd0);
        chk("reset_irq", {63'd0, irq}, 64'd0);
        bus_rd(4'd8, rdv);
        chk("reset_status", {32'd0, rdv}, 64'h14);
        bus_rd(4'd6, rdv);
        chk("dout_hi_empty", {32'd0, rdv}, 64'd0);
        bus_wr(4'd12, 32'hFFFFFFFF);
        bus_rd(4'd12, rdv);
        chk("unmapped_read", {32'd0, rdv}, 64'd0);
        bus_rd(4'd8, rdv);
        chk("status_after_hi_empty", {32'd0, rdv}, 64'h14);

        // ECB vectors
        for (int v = 0; v < 8; v++) begin
            bus_wr(4'd0, {29'd0, 1'b1, 1'b0, vecs[v].dir});
            set_key(vecs[v].key);
            push_blk(vecs[v].din);
            wait_st(32'h10, 32'h0, ok);
            chk($sformatf("ecb%0d_done", v), {63'd0, ok}, 64'd1);
            chk($sformatf("ecb%0d_irq", v), {63'd0, irq}, 64'd1);
            pop_blk(blk);
            chk($sformatf("ecb%0d_dout", v), blk, vecs[v].exp);
            bus_rd(4'd8, rdv);
            chk($sformatf("ecb%0d_status", v), {32'd0, rdv}, 64'h14);
            chk($sformatf("ecb%0d_irq_clr", v), {63'd0, irq}, 64'd0);
        end

        // CBC encrypt two blocks, flush, decrypt them back
        bus_wr(4'd0, 32'h6);
        set_key(80'd0);
        bus_wr(4'd9, 32'd0);
        bus_wr(4'd10, 32'd0);
        push_blk(64'd0);
        push_blk(C_K0_P0);
        wait_st(32'h10, 32'h0, ok);
        pop_blk(blk);
        chk("cbc_enc0", blk, C_K0_P0);
        wait_st(32'h10, 32'h0, ok);
        pop_blk(blk);
        chk("cbc_enc1", blk, C_K0_P0);
        bus_wr(4'd0, 32'hF);
        bus_rd(4'd0, rdv);
        chk("ctrl_readback", {32'd0, rdv}, 64'h7);
        push_blk(C_K0_P0);
        push_blk(C_K0_P0);
        wait_st(32'h10, 32'h0, ok);
        pop_blk(blk);
        chk("cbc_dec0", blk, 64'd0);
        wait_st(32'h10, 32'h0, ok);
        pop_blk(blk);
        chk("cbc_dec1", blk, C_K0_P0);

        // Fill out FIFO, stall engine, fill in FIFO, overflow, drain
        bus_wr(4'd0, 32'h4);
        for (int i = 0; i < 4; i++) begin
            push_blk((i % 2) ? ONES64 : 64'd0);
            wait_st(32'hFF000000, (i + 1) << 24, ok);
            chk($sformatf("fill_out%0d", i), {63'd0, ok}, 64'd1);
        end
        for (int i = 4; i < 8; i++) push_blk((i % 2) ? ONES64 : 64'd0);
        bus_rd(4'd8, rdv);
        chk("stalled_status", {32'd0, rdv}, 64'h0404000A);
        push_blk(64'h1234567812345678);
        push_blk(64'h1234567812345678);
        bus_rd(4'd8, rdv);
        chk("ovf_status", {32'd0, rdv}, 64'h0404004A);
        chk("ovf_irq", {63'd0, irq}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            wait_st(32'h10, 32'h0, ok);
            pop_blk(blk);
            chk($sformatf("drain%0d", i), blk, (i % 2) ? C_K0_PF : C_K0_P0);
        end
        wait_st(32'h1, 32'h0, ok);
        bus_rd(4'd8, rdv);
        chk("drained_status", {32'd0, rdv}, 64'h54);
        bus_rd(4'd7, rdv);
        chk("unf_odat", {32'd0, rdv}, 64'd0);
        bus_rd(4'd8, rdv);
        chk("unf_status", {32'd0, rdv}, 64'hD4);

        // Key write while busy is ignored and flagged
        push_blk(64'd0);
        bus_wr(4'd1, 32'hFFFFFFFF);
        wait_st(32'h10, 32'h0, ok);
        pop_blk(blk);
        chk("busy_key_old", blk, C_K0_P0);
        bus_rd(4'd8, rdv);
        chk("cfg_status", {32'd0, rdv}, 64'h1D4);
        chk("cfg_irq", {63'd0, irq}, 64'd1);
        bus_wr(4'd8, 32'h1E0);
        bus_rd(4'd8, rdv);
        chk("w1c_status", {32'd0, rdv}, 64'h14);
        chk("w1c_irq", {63'd0, irq}, 64'd0);

        // Async reset during WAIT
        push_blk(64'd0);
        repeat (10) @(negedge clk);
        bus_rd(4'd8, rdv);
        chk("busy_before_reset", {63'd0, rdv[0]}, 64'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_odat", {32'd0, odat}, 64'd0);
        chk("mid_reset_irq", {63'd0, irq}, 64'd0);
        bus_rd(4'd8, rdv);
        chk("mid_reset_status", {32'd0, rdv}, 64'h14);
        bus_rd(4'd0, rdv);
        chk("mid_reset_ctrl", {32'd0, rdv}, 64'd0);
        repeat (100) @(negedge clk);
        bus_rd(4'd8, rdv);
        chk("no_late_output", {32'd0, rdv}, 64'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
